// File: rtl/life_row_tracker.sv
// ---------------------------------------------------------------------------
// life_row_tracker
//   Tracks the player's life count and the post-hit invulnerability window
//   with its blink phase. Maps every VGA pixel onto a horizontal row of heart
//   slots and drives the heart bitmap stage (InsideRectangle/offsetX/offsetY).
//
//   Optional feature macro: LIFE_GHOST_EN
//     defined   : lost-heart slots raise ghostHeart and InsideRectangle so the
//                 bitmap stage can draw a dimmed outline (blink does not hide
//                 ghosts).
//     undefined : ghostHeart tied 0, lost slots are outside.
//
//   Ports
//     clk             system clock
//     reset           asynchronous, active-high reset
//     startOfFrame    1-cycle pulse per video frame
//     pixelX/pixelY   current pixel coordinate (11 bits)
//     hit             1-cycle pulse, player damaged
//     bonus           1-cycle pulse, extra life
//     newGame         1-cycle pulse, restore INIT_LIVES
//     InsideRectangle pixel lies in a drawn heart (1 clk after pixelX/Y)
//     offsetX/offsetY offset inside the heart slot, 0 outside any slot
//     ghostHeart      pixel lies in a lost-heart slot (LIFE_GHOST_EN only)
//     lives           current life count
//     invulnerable    invulnerability window active
//     gameOver        no lives left
// ---------------------------------------------------------------------------
module life_row_tracker #(
  parameter int unsigned MAX_LIVES     = 3,
  parameter int unsigned INIT_LIVES    = 3,
  parameter int unsigned TOP_LEFT_X    = 16,
  parameter int unsigned TOP_LEFT_Y    = 8,
  parameter int unsigned HEART_W       = 16,
  parameter int unsigned HEART_H       = 16,
  parameter int unsigned GAP           = 4,
  parameter int unsigned INVULN_FRAMES = 60,
  parameter int unsigned BLINK_FRAMES  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        hit,
  input  logic        bonus,
  input  logic        newGame,
  output logic        InsideRectangle,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic        ghostHeart,
  output logic [2:0]  lives,
  output logic        invulnerable,
  output logic        gameOver
);

  localparam int unsigned CW    = 11;
  localparam int unsigned LW    = 3;
  localparam int unsigned PITCH = HEART_W + GAP;
  localparam int unsigned IW    = $clog2(INVULN_FRAMES + 1);
  localparam int unsigned BW    = $clog2(2 * BLINK_FRAMES);

  typedef enum logic [1:0] {
    PLAY   = 2'd0,
    INVULN = 2'd1,
    OVER   = 2'd2
  } state_t;

  state_t          state_q;
  logic [LW-1:0]   lives_q;
  logic [IW-1:0]   inv_cnt_q;
  logic [BW-1:0]   blink_q;
  logic            invuln_q;
  logic            over_q;

  logic [LW-1:0]   lives_dec_c;
  logic [LW-1:0]   lives_inc_c;
  logic            hide_c;

  logic [CW-1:0]   rx_c;
  logic [CW-1:0]   ry_c;
  logic            row_ok_c;
  logic            in_slot_c;
  logic [LW-1:0]   slot_c;
  logic [CW-1:0]   offx_c;
  logic            drawn_c;
  logic            ghost_c;

  logic            inside_q;
  logic [CW-1:0]   offsetx_q;
  logic [CW-1:0]   offsety_q;
  logic            ghost_q;

  // Saturating life arithmetic
  assign lives_dec_c = (lives_q == '0) ? '0 : lives_q - LW'(1);
  assign lives_inc_c = (lives_q >= LW'(MAX_LIVES)) ? LW'(MAX_LIVES) : lives_q + LW'(1);

  // Hearts vanish during the second half of each blink period
  assign hide_c = invuln_q && (blink_q >= BW'(BLINK_FRAMES));

  // Life / invulnerability FSM; newGame outranks hit, hit outranks bonus
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= PLAY;
      lives_q   <= LW'(INIT_LIVES);
      inv_cnt_q <= '0;
      blink_q   <= '0;
      invuln_q  <= 1'b0;
      over_q    <= 1'b0;
    end else if (newGame) begin
      state_q   <= PLAY;
      lives_q   <= LW'(INIT_LIVES);
      inv_cnt_q <= '0;
      blink_q   <= '0;
      invuln_q  <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      case (state_q)
        PLAY: begin
          if (hit) begin
            lives_q   <= lives_dec_c;
            inv_cnt_q <= IW'(INVULN_FRAMES);
            blink_q   <= '0;
            if (lives_q <= LW'(1)) begin
              state_q <= OVER;
              over_q  <= 1'b1;
            end else begin
              state_q  <= INVULN;
              invuln_q <= 1'b1;
            end
          end else if (bonus) begin
            lives_q <= lives_inc_c;
          end
        end
        INVULN: begin
          if (bonus) begin
            lives_q <= lives_inc_c;
          end
          if (startOfFrame) begin
            if (inv_cnt_q <= IW'(1)) begin
              state_q   <= PLAY;
              invuln_q  <= 1'b0;
              inv_cnt_q <= '0;
              blink_q   <= '0;
            end else begin
              inv_cnt_q <= inv_cnt_q - IW'(1);
              blink_q   <= (blink_q == BW'(2 * BLINK_FRAMES - 1)) ? '0 : blink_q + BW'(1);
            end
          end
        end
        OVER: begin
          state_q <= OVER;
        end
        default: begin
          state_q  <= PLAY;
          invuln_q <= 1'b0;
          over_q   <= 1'b0;
        end
      endcase
    end
  end

  // Slot decode: one range compare per slot, no divider
  always_comb begin
    rx_c      = pixelX - CW'(TOP_LEFT_X);
    ry_c      = pixelY - CW'(TOP_LEFT_Y);
    row_ok_c  = (pixelX >= CW'(TOP_LEFT_X)) && (pixelY >= CW'(TOP_LEFT_Y)) &&
                (ry_c < CW'(HEART_H));
    in_slot_c = 1'b0;
    slot_c    = '0;
    offx_c    = '0;
    for (int unsigned k = 0; k < MAX_LIVES; k++) begin
      if (row_ok_c && (rx_c >= CW'(k * PITCH)) && (rx_c < CW'(k * PITCH + HEART_W))) begin
        in_slot_c = 1'b1;
        slot_c    = LW'(k);
        offx_c    = rx_c - CW'(k * PITCH);
      end
    end
  end

  assign drawn_c = in_slot_c && (slot_c < lives_q) && !hide_c;

`ifdef LIFE_GHOST_EN
  assign ghost_c = in_slot_c && (slot_c >= lives_q);
`else
  assign ghost_c = 1'b0;
`endif

  // Pixel outputs, exactly one clock behind pixelX/pixelY
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inside_q  <= 1'b0;
      offsetx_q <= '0;
      offsety_q <= '0;
      ghost_q   <= 1'b0;
    end else begin
      inside_q  <= drawn_c || ghost_c;
      offsetx_q <= in_slot_c ? offx_c : '0;
      offsety_q <= in_slot_c ? ry_c : '0;
      ghost_q   <= ghost_c;
    end
  end

  assign InsideRectangle = inside_q;
  assign offsetX         = offsetx_q;
  assign offsetY         = offsety_q;
  assign ghostHeart      = ghost_q;
  assign lives           = lives_q;
  assign invulnerable    = invuln_q;
  assign gameOver        = over_q;

endmodule

// File: tb/tb_life_row_tracker.sv
module tb_life_row_tracker;

  logic        clk = 1'b0;
  logic        reset;
  logic        startOfFrame;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        hit;
  logic        bonus;
  logic        newGame;
  logic        InsideRectangle;
  logic [10:0] offsetX;
  logic [10:0] offsetY;
  logic        ghostHeart;
  logic [2:0]  lives;
  logic        invulnerable;
  logic        gameOver;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int ins;
    int ox;
    int oy;
    int gh;
  } pix_t;

  pix_t sb[$];

  always #5 clk = ~clk;

  life_row_tracker dut (
    .clk             (clk),
    .reset           (reset),
    .startOfFrame    (startOfFrame),
    .pixelX          (pixelX),
    .pixelY          (pixelY),
    .hit             (hit),
    .bonus           (bonus),
    .newGame         (newGame),
    .InsideRectangle (InsideRectangle),
    .offsetX         (offsetX),
    .offsetY         (offsetY),
    .ghostHeart      (ghostHeart),
    .lives           (lives),
    .invulnerable    (invulnerable),
    .gameOver        (gameOver)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference pixel map: slot index and offset by division (3 slots, pitch 20)
  function automatic pix_t model(input int x, input int y, input int lv, input bit hide);
    pix_t p;
    int   rx;
    int   ry;
    int   k;
    int   off;
    p.ins = 0; p.ox = 0; p.oy = 0; p.gh = 0;
    rx = x - 16;
    ry = y - 8;
    if (rx >= 0 && ry >= 0 && ry < 16) begin
      k   = rx / 20;
      off = rx % 20;
      if (off < 16 && k < 3) begin
        p.ox = off;
        p.oy = ry;
        if (k < lv && !hide) p.ins = 1;
`ifdef LIFE_GHOST_EN
        if (k >= lv) begin
          p.ins = 1;
          p.gh  = 1;
        end
`endif
      end
    end
    return p;
  endfunction

  task automatic pix(input string tag, input int x, input int y, input int lv, input bit hide);
    pix_t e;
    pixelX = 11'(x);
    pixelY = 11'(y);
    sb.push_back(model(x, y, lv, hide));
    step();
    e = sb.pop_front();
    chk({tag, ".inside"}, int'(InsideRectangle), e.ins);
    chk({tag, ".offx"},   int'(offsetX),         e.ox);
    chk({tag, ".offy"},   int'(offsetY),         e.oy);
    chk({tag, ".ghost"},  int'(ghostHeart),      e.gh);
  endtask

  task automatic ev(input bit h, input bit b, input bit n);
    hit = h; bonus = b; newGame = n;
    step();
    hit = 1'b0; bonus = 1'b0; newGame = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      startOfFrame = 1'b1;
      step();
      startOfFrame = 1'b0;
    end
  endtask

  task automatic status(input string tag, input int lv, input int inv, input int over);
    chk({tag, ".lives"},    int'(lives),        lv);
    chk({tag, ".invuln"},   int'(invulnerable), inv);
    chk({tag, ".gameover"}, int'(gameOver),     over);
  endtask

  initial begin
    reset = 1'b1; startOfFrame = 1'b0; hit = 1'b0; bonus = 1'b0; newGame = 1'b0;
    pixelX = 11'd0; pixelY = 11'd0;
    step();
    step();
    status("rst", 3, 0, 0);
    chk("rst.inside", int'(InsideRectangle), 0);
    chk("rst.offx",   int'(offsetX), 0);
    chk("rst.offy",   int'(offsetY), 0);
    chk("rst.ghost",  int'(ghostHeart), 0);
    reset = 1'b0;

    // Geometry at full lives
    pix("p_origin", 16, 8, 3, 1'b0);
    pix("p_slot1_end", 51, 23, 3, 1'b0);
    pix("p_gap", 32, 8, 3, 1'b0);
    pix("p_slot3", 76, 8, 3, 1'b0);
    pix("p_left", 15, 8, 3, 1'b0);
    pix("p_above", 16, 7, 3, 1'b0);
    pix("p_below", 16, 24, 3, 1'b0);
    pix("p_slot2_end", 71, 12, 3, 1'b0);

    // Hit, then a second hit inside the window is ignored
    ev(1'b1, 1'b0, 1'b0);
    status("hit1", 2, 1, 0);
    repeat (5) step();
    ev(1'b1, 1'b0, 1'b0);
    status("hit_ignored", 2, 1, 0);
    pix("p_lost2", 56, 8, 2, 1'b0);

    // Blink through the whole invulnerability window
    for (int f = 1; f <= 60; f++) begin
      frames(1);
      pix("blink", 16, 8, 2, (f < 60) && ((f % 16) >= 8));
      chk("blink.invuln", int'(invulnerable), (f < 60) ? 1 : 0);
    end
    status("inv_done", 2, 0, 0);

    // Bonus and saturation, hit beats bonus
    ev(1'b0, 1'b1, 1'b0);
    status("bonus", 3, 0, 0);
    ev(1'b0, 1'b1, 1'b0);
    status("bonus_sat", 3, 0, 0);
    ev(1'b1, 1'b1, 1'b0);
    status("hit_bonus", 2, 1, 0);
    ev(1'b0, 1'b1, 1'b0);
    status("bonus_inv", 3, 1, 0);
    frames(60);
    status("inv_done2", 3, 0, 0);

    // Run down to game over
    ev(1'b1, 1'b0, 1'b0);
    status("down2", 2, 1, 0);
    frames(60);
    ev(1'b1, 1'b0, 1'b0);
    status("down1", 1, 1, 0);
    pix("p_ghost", 56, 8, 1, 1'b0);
    pix("p_live1", 16, 8, 1, 1'b0);
    frames(60);
    ev(1'b1, 1'b0, 1'b0);
    status("over", 0, 0, 1);
    pix("p_over", 16, 8, 0, 1'b0);
    ev(1'b0, 1'b1, 1'b0);
    status("over_bonus", 0, 0, 1);
    ev(1'b1, 1'b0, 1'b0);
    status("over_hit", 0, 0, 1);
    ev(1'b0, 1'b0, 1'b1);
    status("newgame", 3, 0, 0);
    ev(1'b1, 1'b0, 1'b1);
    status("newgame_hit", 3, 0, 0);
    ev(1'b1, 1'b0, 1'b0);
    status("hit_after_ng", 2, 1, 0);

    // Asynchronous reset between clock edges
    pix("p_pre_rst", 20, 10, 2, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    status("async_rst", 3, 0, 0);
    chk("async_rst.inside", int'(InsideRectangle), 0);
    chk("async_rst.offx",   int'(offsetX), 0);
    chk("async_rst.offy",   int'(offsetY), 0);
    step();
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
